// File: rtl/alu_operand_entry_if.sv
// Board-side bundle for the operand-entry block: switches, raw buttons and
// ALU status in, operands/opcode/display data out.
interface alu_operand_entry_if #(
    parameter int W = 32
);
    logic [7:0]   sw;
    logic         btn_a;
    logic         btn_b;
    logic         btn_op;
    logic         btn_show;
    logic [W-1:0] F;
    logic         ZF;
    logic         OF;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALU_OP;
    logic [W-1:0] Data;
    logic [1:0]   sel;

    modport master (
        output sw, btn_a, btn_b, btn_op, btn_show, F, ZF, OF,
        input  A, B, ALU_OP, Data, sel
    );

    modport slave (
        input  sw, btn_a, btn_b, btn_op, btn_show, F, ZF, OF,
        output A, B, ALU_OP, Data, sel
    );
endinterface

// File: rtl/alu_operand_entry.sv
// Operand/opcode entry from switches and debounced buttons, with a registered
// display mux feeding the hex display driver.
module alu_operand_entry_db #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic pulse_o
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synced level agrees with the stable level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1))
                stable_d = sync2_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;
endmodule

module alu_operand_entry #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int W         = 32
) (
    input  logic clk,
    input  logic rst,
    alu_operand_entry_if.slave io
);
    localparam int NUM_BTN = 4;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] pulse;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         sel_q, sel_d;
    logic [W-1:0]       data_q, data_d;

    // Bit order: 0=A, 1=B, 2=opcode, 3=display select.
    assign raw = {io.btn_show, io.btn_op, io.btn_b, io.btn_a};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        alu_operand_entry_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw[g]),
            .pulse_o (pulse[g])
        );
    end

    always_comb begin
        a_d   = pulse[0] ? ((a_q << 8) | W'(io.sw)) : a_q;
        b_d   = pulse[1] ? ((b_q << 8) | W'(io.sw)) : b_q;
        op_d  = pulse[2] ? io.sw[3:0] : op_q;
        sel_d = pulse[3] ? sel_q + 2'd1 : sel_q;
        unique case (sel_q)
            2'd0:    data_d = a_q;
            2'd1:    data_d = b_q;
            2'd2:    data_d = io.F;
            default: data_d = W'({3'b000, io.OF, 3'b000, io.ZF});
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    assign io.A      = a_q;
    assign io.B      = b_q;
    assign io.ALU_OP = op_q;
    assign io.sel    = sel_q;
    assign io.Data   = data_q;
endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Sits directly upstream of the board's 8-digit hex display driver and feeds its 32-bit Data input.
- Lets the user build ALU operands A and B byte-by-byte from 8 switches and set the 4-bit ALU opcode, using debounced push-buttons.
- Drives A, B and opcode into the ALU.
- Selects which value goes to the display: A, B, the ALU result F, or the flags.

Parameters:
- DB_CYCLES, 1_000_000: clock cycles a raw button level must be stable before it is accepted (20 ms at 50 MHz). Sims use 4.
- W, 32: operand/result width. Must be a multiple of 8.

Ports:
- clk  input  1  system clock, 50 MHz on board
- rst  input  1  asynchronous, active-high reset
- sw  input  8  data switches
- btn_a  input  1  raw button: shift sw into A
- btn_b  input  1  raw button: shift sw into B
- btn_op  input  1  raw button: load sw[3:0] into ALU_OP
- btn_show  input  1  raw button: advance display select
- F  input  W  ALU result
- ZF  input  1  ALU zero flag
- OF  input  1  ALU overflow flag
- A  output  W  operand A to ALU
- B  output  W  operand B to ALU
- ALU_OP  output  4  opcode to ALU
- Data  output  W  value to display driver
- sel  output  2  current display select, for status LEDs

Behaviour:
- Reset (async, active-high): A=0, B=0, ALU_OP=0, sel=0, Data=0. All synchroniser flops, debounce counters, stable levels and edge pulses = 0. Reset mid-debounce discards the partial count.
- Debouncer, one instance per button:
  - Raw input goes through a 2-flop synchroniser.
  - If synced level equals the stable level, the counter clears.
  - Otherwise the counter increments. When the counter reaches DB_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes the stable level.
- Press pulse: a single-cycle pulse on each stable 0->1 transition. Nothing fires on release. Holding a button produces exactly one pulse.
- Latency: the pulse fires DB_CYCLES+3 clk edges after the first edge that samples the raw input high. Bench tolerance is ±1.
- Pulse actions, all taking effect on the edge after the pulse:
  - a_pulse: A <= {A[W-9:0], sw}. The oldest byte falls off the top, so 4 presses fill 32 bits.
  - b_pulse: B <= {B[W-9:0], sw}.
  - op_pulse: ALU_OP <= sw[3:0].
  - show_pulse: sel <= sel+1, wrapping 3->0.
- Simultaneous pulses are independent. Each updates its own register in the same cycle with no priority.
- Data is registered every cycle from the mux:
  - sel=0: A
  - sel=1: B
  - sel=2: F
  - sel=3: {(W-8)'b0, 3'b0, OF, 3'b0, ZF}, so the display shows 000000<OF><ZF>.
- The mux uses the current-cycle sel and register values, so Data lags any A, B, sel or F change by exactly one clk.
- With sel=2, Data follows F continuously with one-cycle delay, regardless of button activity.
- All state is in the clk domain. No combinational path runs from inputs to outputs.

Test Plan:
- Reset and idle (DB_CYCLES=4): assert rst mid-cycle -> all outputs 0 immediately. Release, hold all buttons low for 50 cycles -> outputs stay 0.
- Operand entry: sw=8'h12, 8'h34, 8'h56, 8'h78, then 8'h9A, each with a clean btn_a press -> A=32'h12345678 after the 4th press, 32'h3456789A after the 5th. Data=A one cycle after each update (sel=0).
- Debounce: 3-cycle btn_b glitch -> no change. Bouncing pattern for 20 cycles, then held high 40 cycles -> exactly one shift into B, pulse at DB_CYCLES+3±1 after the last rising edge. Release -> no action.
- Display cycling: press btn_show 5 times with A=1, B=2, F=32'hDEADBEEF, ZF=1, OF=0 -> sel goes 1,2,3,0,1. Data goes 2, DEADBEEF, 00000001, 1, 2. With sel=2, changing F to 0 -> Data=0 the next cycle.
- Opcode and simultaneous presses: sw=8'hA5, btn_op and btn_a pressed on the same cycle -> ALU_OP=4'h5 and A shifted by 8'hA5 on the same edge.
- Reset mid-operation: assert rst during a btn_a debounce count -> after release, no shift occurs unless btn_a is held a full DB_CYCLES again. A=0.
